fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC value, issues one 16-bit instruction read to instruction memory, and holds the returned word for the decoder behind a valid/ready handshake.
- Drives the PC's enable/write/load inputs: increments by 2 on each accepted fetch, or loads a target on redirect (branch/jump).
- Single outstanding memory request; wrong-path responses are discarded after a redirect.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one 16-bit read per PC value, holds the returned
// word for the decoder, and steers the PC register (increment by 2 or redirect load).
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic [ADDR_W-1:0] I_pc,
  output logic              O_pc_enable,
  output logic              O_pc_write,
  output logic [ADDR_W-1:0] O_pc_in,
  output logic              O_mem_req,
  output logic [ADDR_W-1:0] O_mem_addr,
  input  logic              I_mem_ack,
  input  logic              I_mem_rvalid,
  input  logic [DATA_W-1:0] I_mem_rdata,
  output logic              O_instr_valid,
  output logic [DATA_W-1:0] O_instr,
  output logic [ADDR_W-1:0] O_instr_pc,
  input  logic              I_instr_ready,
  input  logic              I_redirect,
  input  logic [ADDR_W-1:0] I_redirect_pc
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, FULL, DROP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              w_load_instr;
  logic              w_capture_pc;

  always_comb begin
    w_next_state  = r_state;
    O_pc_enable   = 1'b0;
    O_pc_write    = 1'b0;
    O_mem_req     = 1'b0;
    O_instr_valid = 1'b0;
    w_load_instr  = 1'b0;
    w_capture_pc  = 1'b0;
    case (r_state)
      IDLE: w_next_state = FETCH;
      FETCH: begin
        O_mem_req = !I_redirect;
        if (I_redirect) begin
          O_pc_enable = 1'b1;
          O_pc_write  = 1'b1;
        end else if (I_mem_ack) begin
          O_pc_enable  = 1'b1;
          w_capture_pc = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // A redirect with the response still in flight must swallow it in DROP.
        if (I_redirect) begin
          O_pc_enable  = 1'b1;
          O_pc_write   = 1'b1;
          w_next_state = I_mem_rvalid ? FETCH : DROP;
        end else if (I_mem_rvalid) begin
          w_load_instr = 1'b1;
          w_next_state = FULL;
        end
      end
      FULL: begin
        O_instr_valid = !I_redirect;
        if (I_redirect) begin
          O_pc_enable  = 1'b1;
          O_pc_write   = 1'b1;
          w_next_state = FETCH;
        end else if (I_instr_ready) begin
          w_next_state = FETCH;
        end
      end
      DROP: begin
        if (I_redirect) begin
          O_pc_enable = 1'b1;
          O_pc_write  = 1'b1;
        end
        if (I_mem_rvalid) w_next_state = FETCH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign O_mem_addr = (r_state == IDLE) ? '0 : I_pc;
  assign O_pc_in    = (I_redirect && (r_state != IDLE)) ? {I_redirect_pc[ADDR_W-1:1], 1'b0} : '0;
  assign O_instr    = r_instr;
  assign O_instr_pc = r_instr_pc;

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_fetch_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture_pc) r_fetch_pc <= I_pc;
      if (w_load_instr) begin
        r_instr    <= I_mem_rdata;
        r_instr_pc <= r_fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and memory environment models plus
// a transaction-level expectation model (in-flight / held / wrong-path) and an order scoreboard.
module tb_fetch_unit;

  logic        I_clk = 1'b0;
  logic        I_reset = 1'b0;
  logic [15:0] I_pc = '0;
  logic        O_pc_enable, O_pc_write, O_mem_req, O_instr_valid;
  logic [15:0] O_pc_in, O_mem_addr, O_instr, O_instr_pc;
  logic        I_mem_ack = 1'b0, I_mem_rvalid = 1'b0, I_instr_ready = 1'b0, I_redirect = 1'b0;
  logic [15:0] I_mem_rdata = '0, I_redirect_pc = '0;

  fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_pc(I_pc),
    .O_pc_enable(O_pc_enable), .O_pc_write(O_pc_write), .O_pc_in(O_pc_in),
    .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr), .I_mem_ack(I_mem_ack),
    .I_mem_rvalid(I_mem_rvalid), .I_mem_rdata(I_mem_rdata),
    .O_instr_valid(O_instr_valid), .O_instr(O_instr), .O_instr_pc(O_instr_pc),
    .I_instr_ready(I_instr_ready), .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc)
  );

  always #5 I_clk = ~I_clk;

  int assertCount = 0;
  int failCount = 0;

  logic [15:0] pcModel = '0;
  bit          mbusy = 0;
  int          mcount = 0;
  logic [15:0] maddr = '0;
  bit          held = 0;
  bit          good = 0;
  logic [15:0] heldAddr = '0;
  logic [15:0] expNext = '0;
  int          since = 0;
  int          handshakes = 0;
  int          idleRun = 0;

  logic        obsReq, obsEn, obsWr, obsValid;
  logic [15:0] obsAddr, obsPcIn, obsInstr, obsInstrPc;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: drive, check combinational/held outputs, advance models.
  task automatic applyStimulus(input bit rdy, input bit ack, input bit redir,
                               input logic [15:0] tgt, input int lat);
    bit rv, idle, expReq, expEn, expWr, expValid;
    logic [15:0] tgtAl, pcNext;
    idle   = (since == 0);
    rv     = mbusy && (mcount == 0);
    tgtAl  = {tgt[15:1], 1'b0};
    I_mem_rvalid  = rv;
    I_mem_rdata   = rv ? memf(maddr) : 16'($urandom);
    I_mem_ack     = ack;
    I_redirect    = redir;
    I_redirect_pc = tgt;
    I_instr_ready = rdy;
    expReq   = !idle && !mbusy && !held && !redir;
    expValid = held && !redir;
    expEn    = !idle && (redir || (expReq && ack));
    expWr    = !idle && redir;
    #1;
    obsReq = O_mem_req; obsEn = O_pc_enable; obsWr = O_pc_write; obsValid = O_instr_valid;
    obsAddr = O_mem_addr; obsPcIn = O_pc_in; obsInstr = O_instr; obsInstrPc = O_instr_pc;

    checkOutput("mem_req", 32'(obsReq), 32'(expReq));
    if (expReq) checkOutput("mem_addr", 32'(obsAddr), 32'(pcModel));
    checkOutput("pc_enable", 32'(obsEn), 32'(expEn));
    checkOutput("pc_write", 32'(obsWr), 32'(expWr));
    checkOutput("pc_in", 32'(obsPcIn), (redir && !idle) ? 32'(tgtAl) : 32'h0);
    checkOutput("instr_valid", 32'(obsValid), 32'(expValid));
    if (expValid) begin
      checkOutput("instr_pc", 32'(obsInstrPc), 32'(heldAddr));
      checkOutput("instr", 32'(obsInstr), 32'(memf(heldAddr)));
    end
    if (expValid && rdy) begin
      checkOutput("order", 32'(obsInstrPc), 32'(expNext));
      expNext = expNext + 16'd2;
      handshakes++;
      idleRun = 0;
    end else begin
      idleRun++;
    end

    if (redir && !idle) begin
      expNext = tgtAl;
      held = 0;
      if (mbusy && !rv) good = 0;
    end else if (rv && good) begin
      held = 1;
      heldAddr = maddr;
    end else if (held && rdy) begin
      held = 0;
    end
    if (expReq && ack) good = 1;

    pcNext = O_pc_enable ? (O_pc_write ? O_pc_in : pcModel + 16'd2) : pcModel;
    if (rv) mbusy = 0;
    else if (mbusy && mcount > 0) mcount--;
    if (O_mem_req && ack) begin
      mbusy = 1;
      maddr = O_mem_addr;
      mcount = lat - 1;
    end

    @(posedge I_clk);
    #1;
    pcModel = pcNext;
    I_pc = pcModel;
    since++;
  endtask

  task automatic doReset();
    I_reset = 1'b0;
    I_redirect = 1'b0; I_instr_ready = 1'b0; I_mem_ack = 1'b0; I_mem_rvalid = 1'b0;
    #1;
    checkOutput("rst_mem_req", 32'(O_mem_req), 0);
    checkOutput("rst_mem_addr", 32'(O_mem_addr), 0);
    checkOutput("rst_pc_enable", 32'(O_pc_enable), 0);
    checkOutput("rst_pc_write", 32'(O_pc_write), 0);
    checkOutput("rst_pc_in", 32'(O_pc_in), 0);
    checkOutput("rst_valid", 32'(O_instr_valid), 0);
    checkOutput("rst_instr", 32'(O_instr), 0);
    checkOutput("rst_instr_pc", 32'(O_instr_pc), 0);
    pcModel = '0; I_pc = '0; mbusy = 0; mcount = 0; held = 0; good = 0; expNext = '0; idleRun = 0;
    repeat (2) @(posedge I_clk);
    #1;
    I_reset = 1'b1;
    since = 0;
  endtask

  initial begin
    @(posedge I_clk);
    #1;
    doReset();

    applyStimulus(1, 1, 0, 16'h0, 1);
    checkOutput("t1_idle_req", 32'(obsReq), 0);
    applyStimulus(1, 1, 0, 16'h0, 1);
    checkOutput("t1_req", 32'(obsReq), 1);
    checkOutput("t1_addr", 32'(obsAddr), 32'h0000);
    checkOutput("t1_inc", 32'({obsEn, obsWr}), 32'b10);
    applyStimulus(0, 1, 0, 16'h0, 1);
    checkOutput("t1_wait_valid", 32'(obsValid), 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 16'h0, 1);
      checkOutput("t2_valid", 32'(obsValid), 1);
      checkOutput("t2_instr", 32'(obsInstr), 32'h1234);
      checkOutput("t2_instr_pc", 32'(obsInstrPc), 32'h0000);
      checkOutput("t2_req", 32'(obsReq), 0);
      checkOutput("t2_pc_enable", 32'(obsEn), 0);
    end
    applyStimulus(1, 1, 0, 16'h0, 1);
    applyStimulus(1, 1, 0, 16'h0, 4);
    checkOutput("t2_resume_req", 32'(obsReq), 1);
    checkOutput("t2_resume_addr", 32'(obsAddr), 32'h0002);

    applyStimulus(1, 1, 1, 16'h0100, 1);
    checkOutput("t3_load", 32'({obsEn, obsWr}), 32'b11);
    checkOutput("t3_pc_in", 32'(obsPcIn), 32'h0100);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 16'h0, 1);
      checkOutput("t3_drop_valid", 32'(obsValid), 0);
    end
    applyStimulus(1, 1, 0, 16'h0, 1);
    checkOutput("t3_addr", 32'(obsAddr), 32'h0100);
    checkOutput("t3_valid", 32'(obsValid), 0);
    applyStimulus(1, 1, 0, 16'h0, 1);

    applyStimulus(1, 1, 1, 16'h0200, 1);
    checkOutput("t4_valid", 32'(obsValid), 0);
    checkOutput("t4_pc_in", 32'(obsPcIn), 32'h0200);
    applyStimulus(1, 1, 0, 16'h0, 2);
    checkOutput("t4_addr", 32'(obsAddr), 32'h0200);
    applyStimulus(1, 1, 0, 16'h0, 2);

    doReset();
    applyStimulus(1, 0, 0, 16'h0, 1);
    checkOutput("t5_idle_req", 32'(obsReq), 0);
    applyStimulus(1, 0, 0, 16'h0, 1);
    checkOutput("t5_req", 32'(obsReq), 1);
    checkOutput("t5_addr", 32'(obsAddr), 32'h0000);

    applyStimulus(1, 1, 1, 16'h0101, 1);
    checkOutput("t6_pc_in_align", 32'(obsPcIn), 32'h0100);
    applyStimulus(1, 1, 1, 16'hFFFF, 1);
    checkOutput("t6_pc_in_top", 32'(obsPcIn), 32'hFFFE);
    applyStimulus(1, 1, 0, 16'h0, 1);
    checkOutput("t6_addr_top", 32'(obsAddr), 32'hFFFE);
    applyStimulus(1, 1, 0, 16'h0, 1);
    applyStimulus(1, 1, 0, 16'h0, 1);
    checkOutput("t6_instr_pc", 32'(obsInstrPc), 32'hFFFE);
    applyStimulus(1, 0, 0, 16'h0, 1);
    checkOutput("t6_wrap_addr", 32'(obsAddr), 32'h0000);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0,
                    (since > 0) && (($urandom % 12) == 0),
                    16'($urandom), int'($urandom_range(1, 4)));
      if (idleRun > 100) begin
        checkOutput("liveness", 32'(idleRun), 0);
        break;
      end
    end
    checkOutput("progress", 32'(handshakes > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
